// File: rtl/radio_pkg.sv
// Shared types and defaults for the RC receiver pulse-capture block.
package radio_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } ch_state_t;

    localparam logic [2:0] RC_A_VALID = 3'd6;
    localparam logic [2:0] RC_A_ERR   = 3'd7;

    localparam int unsigned DEF_N_CH       = 6;
    localparam int unsigned DEF_TICK_DIV   = 50;
    localparam int unsigned DEF_MIN_US     = 800;
    localparam int unsigned DEF_MAX_US     = 2200;
    localparam int unsigned DEF_TIMEOUT_US = 25000;

endpackage

// File: rtl/radio_capture_channel.sv
// One RC channel: synchronizer, edge detect, width FSM and loss timeout.
module radio_channel
    import radio_pkg::*;
#(
    parameter int unsigned MIN_US     = DEF_MIN_US,
    parameter int unsigned MAX_US     = DEF_MAX_US,
    parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic        pulse_i,
    output logic [15:0] width_o,
    output logic        valid_o,
    output logic        err_pulse_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_US + 1);

    logic          sync1_q, sync2_q, s_q, sd_q;
    logic [1:0]    prime_q;
    ch_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   width_q, width_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d;
    logic          rise, fall, primed;

    assign rise   = s_q & ~sd_q;
    assign fall   = ~s_q & sd_q;
    // The sync chain restarts at 0 after reset; a line already high would look
    // like a fresh rise, so WAIT_LOW is left only once s_q reflects the pin.
    assign primed = (prime_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            s_q     <= 1'b0;
            sd_q    <= 1'b0;
            prime_q <= '0;
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            s_q     <= sync2_q;
            sd_q    <= s_q;
            prime_q <= primed ? prime_q : prime_q + 2'd1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;

        if (tick_i && tmo_q != TW'(TIMEOUT_US)) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TW'(TIMEOUT_US - 1)) valid_d = 1'b0;
        end

        // A good pulse below overrides a timeout firing in the same cycle.
        unique case (state_q)
            WAIT_LOW: begin
                if (primed && !s_q) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (cnt_q >= 16'(MIN_US) && cnt_q <= 16'(MAX_US)) begin
                        width_d = cnt_q;
                        valid_d = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = WAIT_RISE;
                end else if (cnt_q > 16'(MAX_US)) begin
                    err_d   = 1'b1;
                    state_d = WAIT_LOW;
                end else if (tick_i) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    assign width_o     = width_q;
    assign valid_o     = valid_q;
    assign err_pulse_o = err_d;

endmodule

// File: rtl/radio_capture.sv
// RC receiver capture: per-channel pulse widths in us, live flags, error count.
module radio_capture
    import radio_pkg::*;
#(
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned MIN_US     = DEF_MIN_US,
    parameter int unsigned MAX_US     = DEF_MAX_US,
    parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [2:0]           A,
    output logic [31:0]          RD,
    input  logic [N_CH-1:0]      RADIO,
    output logic [N_CH*16-1:0]   CH_WIDTH,
    output logic [N_CH-1:0]      CH_VALID
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [N_CH-1:0] err_pulse;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Simultaneous errors on several channels count once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (|err_pulse && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        radio_channel #(
            .MIN_US     (MIN_US),
            .MAX_US     (MAX_US),
            .TIMEOUT_US (TIMEOUT_US)
        ) u_ch (
            .clk_i       (CLK),
            .rst_i       (RESET),
            .tick_i      (tick),
            .pulse_i     (RADIO[i]),
            .width_o     (CH_WIDTH[16*i +: 16]),
            .valid_o     (CH_VALID[i]),
            .err_pulse_o (err_pulse[i])
        );
    end

    always_comb begin
        RD = '0;
        if (A == RC_A_VALID) begin
            RD = 32'(CH_VALID);
        end else if (A == RC_A_ERR) begin
            RD = {16'b0, err_cnt_q};
        end else if (32'(A) < N_CH) begin
            RD = {CH_VALID[A], 15'b0, CH_WIDTH[16*A +: 16]};
        end
    end

endmodule

// File: tb/tb_radio_capture.sv
// Scoreboard bench for radio_capture with a scaled-down time base.
module tb_radio_capture;

    localparam int unsigned N_CH       = 6;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned MIN_US     = 40;
    localparam int unsigned MAX_US     = 110;
    localparam int unsigned TIMEOUT_US = 400;
    localparam int unsigned TO_LO = 4 + (TIMEOUT_US - 1) * TICK_DIV + 1;
    localparam int unsigned TO_HI = 4 + TIMEOUT_US * TICK_DIV;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [2:0]          A;
    logic [31:0]         RD;
    logic [N_CH-1:0]     RADIO;
    logic [N_CH*16-1:0]  CH_WIDTH;
    logic [N_CH-1:0]     CH_VALID;

    radio_capture #(
        .N_CH       (N_CH),
        .TICK_DIV   (TICK_DIV),
        .MIN_US     (MIN_US),
        .MAX_US     (MAX_US),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .A        (A),
        .RD       (RD),
        .RADIO    (RADIO),
        .CH_WIDTH (CH_WIDTH),
        .CH_VALID (CH_VALID)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned ch;
        int unsigned w;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_err_q[$];
    int unsigned err_model;
    int unsigned last_w[N_CH];
    int unsigned pend_fall[N_CH];
    int unsigned good_fall[N_CH];
    int unsigned prev_good_fall[N_CH];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit near(input int unsigned a, input int unsigned b);
        return (a + 1 >= b) && (a <= b + 1);
    endfunction

    // Observes DUT outputs; A is held at the ERR_CNT index except inside rd().
    logic [N_CH*16-1:0] pw;
    logic [N_CH-1:0]    pv;
    logic [15:0]        perr;
    always @(negedge CLK) begin
        if (!mon_en || RESET) begin
            pw   = CH_WIDTH;
            pv   = CH_VALID;
            perr = RD[15:0];
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                int unsigned wnow;
                int idx;
                wnow = 32'(CH_WIDTH[16*ch +: 16]);
                if (wnow != 32'(pw[16*ch +: 16]) || (CH_VALID[ch] && !pv[ch])) begin
                    idx = -1;
                    foreach (exp_q[i]) if (idx < 0 && exp_q[i].ch == ch) idx = i;
                    check($sformatf("update_expected_ch%0d", ch), idx >= 0, wnow, 0);
                    if (idx >= 0) begin
                        check($sformatf("width_ch%0d", ch), near(wnow, exp_q[idx].w), wnow, exp_q[idx].w);
                        check($sformatf("valid_set_ch%0d", ch), CH_VALID[ch] == 1'b1, CH_VALID[ch], 1);
                        check($sformatf("latency_ch%0d", ch), cyc - pend_fall[ch] == 4, cyc - pend_fall[ch], 4);
                        exp_q.delete(idx);
                    end
                end else if (pv[ch] && !CH_VALID[ch]) begin
                    int unsigned d1, d0;
                    d1 = cyc - good_fall[ch];
                    d0 = cyc - prev_good_fall[ch];
                    check($sformatf("timeout_time_ch%0d", ch),
                          (d1 >= TO_LO && d1 <= TO_HI) || (d0 >= TO_LO && d0 <= TO_HI), d1, TO_LO);
                end
            end
            if (RD[15:0] != perr) begin
                check("err_expected", exp_err_q.size() > 0, RD[15:0], perr);
                if (exp_err_q.size() > 0) check("err_cnt", 32'(RD[15:0]) == exp_err_q.pop_front(), RD[15:0], err_model);
            end
            pw   = CH_WIDTH;
            pv   = CH_VALID;
            perr = RD[15:0];
        end
    end

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge CLK);
        #1 A = a;
        #1 d = RD;
        A = 3'd7;
    endtask

    task automatic idle(input int unsigned us);
        repeat (us * TICK_DIV) @(posedge CLK);
    endtask

    task automatic push_err();
        if (err_model != 32'hFFFF) err_model++;
        exp_err_q.push_back(err_model);
    endtask

    task automatic pulse_set(input int unsigned w[N_CH]);
        int unsigned shorts[$];
        int unsigned maxc;
        bit stuck, seen;
        maxc  = 0;
        stuck = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (w[ch] == 0) continue;
            if (w[ch] * TICK_DIV > maxc) maxc = w[ch] * TICK_DIV;
            if (w[ch] >= MIN_US && w[ch] <= MAX_US) begin
                exp_q.push_back('{ch: ch, w: w[ch]});
                last_w[ch] = w[ch];
            end else if (w[ch] < MIN_US) begin
                seen = 1'b0;
                foreach (shorts[i]) if (shorts[i] == w[ch]) seen = 1'b1;
                if (!seen) shorts.push_back(w[ch]);
            end else begin
                stuck = 1'b1;
            end
        end
        shorts.sort();
        foreach (shorts[i]) push_err();
        if (stuck) push_err();
        @(posedge CLK);
        #1;
        for (int ch = 0; ch < N_CH; ch++) if (w[ch] != 0) RADIO[ch] = 1'b1;
        for (int unsigned t = 1; t <= maxc; t++) begin
            @(posedge CLK);
            #1;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (w[ch] != 0 && w[ch] * TICK_DIV == t) begin
                    RADIO[ch]     = 1'b0;
                    pend_fall[ch] = cyc;
                    if (w[ch] >= MIN_US && w[ch] <= MAX_US) begin
                        prev_good_fall[ch] = good_fall[ch];
                        good_fall[ch]      = cyc;
                    end
                end
            end
        end
    endtask

    task automatic pulse1(input int unsigned ch, input int unsigned w);
        int unsigned ws[N_CH];
        foreach (ws[i]) ws[i] = 0;
        ws[ch] = w;
        pulse_set(ws);
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || exp_err_q.size() != 0) && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        check({name, "_drain"}, exp_q.size() == 0 && exp_err_q.size() == 0,
              exp_q.size() + exp_err_q.size(), 0);
    endtask

    task automatic check_ch(input string name, input logic [2:0] a, input bit v, input int unsigned w);
        logic [31:0] d;
        rd(a, d);
        check(name, d[31] == v && d[30:16] == '0 && near(32'(d[15:0]), w), d, {v, 15'b0, w[15:0]});
    endtask

    task automatic check_rd(input string name, input logic [2:0] a, input logic [31:0] e);
        logic [31:0] d;
        rd(a, d);
        check(name, d == e, d, e);
    endtask

    initial begin
        int unsigned ws[N_CH];
        int unsigned w, ch;
        logic [31:0] d;
        RESET = 1'b1;
        RADIO = '0;
        A     = 3'd7;
        err_model = 0;
        foreach (last_w[i]) begin
            last_w[i] = 0; pend_fall[i] = 0; good_fall[i] = 0; prev_good_fall[i] = 0;
        end
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        #1 mon_en = 1'b1;

        for (int a = 0; a < 8; a++) check_rd($sformatf("reset_rd_a%0d", a), 3'(a), 32'h0);

        // Good mid-range pulse.
        pulse1(0, 75);
        drain("t1");
        check_ch("t1_a0", 3'd0, 1'b1, 75);
        check_rd("t1_a6", 3'd6, 32'h01);
        check_rd("t1_a7", 3'd7, 32'h0);

        // Too short.
        pulse1(1, 25);
        drain("t2");
        check_rd("t2_a1", 3'd1, 32'h0);
        check_rd("t2_a7", 3'd7, 32'h1);

        // Stuck high, then recover.
        pulse1(2, 150);
        idle(10);
        pulse1(2, 50);
        drain("t3");
        check_ch("t3_a2", 3'd2, 1'b1, 50);
        check_rd("t3_a7", 3'd7, 32'h2);

        // Loss of signal: valid drops, width holds.
        pulse1(3, 60);
        idle(TIMEOUT_US + 10);
        drain("t4");
        check_ch("t4_a3", 3'd3, 1'b0, 60);
        rd(3'd6, d);
        check("t4_valid3", d[3] == 1'b0, d, 0);

        // Acceptance boundaries.
        pulse1(5, MIN_US + 1); idle(10);
        pulse1(5, MIN_US - 1); idle(10);
        pulse1(5, MAX_US);     idle(10);
        pulse1(5, MAX_US + 2); idle(10);
        drain("bound");
        check_ch("bound_a5", 3'd5, 1'b1, MAX_US);
        check_rd("bound_a7", 3'd7, err_model);

        // Reset in the middle of a pulse.
        @(posedge CLK);
        #1 RADIO[4] = 1'b1;
        idle(15);
        mon_en = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        #1 mon_en = 1'b1;
        err_model = 0;
        foreach (last_w[i]) last_w[i] = 0;
        idle(60);
        @(posedge CLK);
        #1 RADIO[4] = 1'b0;
        idle(20);
        check_rd("t5_a4", 3'd4, 32'h0);
        check_rd("t5_a7", 3'd7, 32'h0);
        pulse1(4, 90);
        drain("t5");
        check_ch("t5_a4_next", 3'd4, 1'b1, 90);

        // All channels together, then a two-channel error in one cycle.
        ws = '{50, 60, 70, 80, 90, 100};
        pulse_set(ws);
        drain("t6");
        for (int a = 0; a < N_CH; a++) check_ch($sformatf("t6_a%0d", a), 3'(a), 1'b1, ws[a]);
        check_rd("t6_a6", 3'd6, 32'h3F);
        ws = '{20, 20, 0, 0, 0, 0};
        pulse_set(ws);
        drain("t6_err");
        check_rd("t6_a7", 3'd7, 32'h1);

        // Randomized single-channel traffic.
        for (int n = 0; n < 40; n++) begin
            ch = $urandom_range(0, N_CH - 1);
            do begin
                w = $urandom_range(MIN_US - 15, MAX_US + 20);
            end while (w == MIN_US || w == MAX_US + 1 ||
                       (w > MIN_US && w <= MAX_US && near(w, last_w[ch] + 1) ) ||
                       (w > MIN_US && w <= MAX_US && (w + 2 >= last_w[ch] && w <= last_w[ch] + 2)));
            pulse1(ch, w);
            idle($urandom_range(5, 40));
        end
        drain("rand");
        check_rd("rand_a7", 3'd7, err_model);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
